code_monitor: RTL
=================

CODE_MONITOR -- requirements
Module: code_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each per-code hit counter and of the error counter.
REQ-002 SHALL have parameter NCODE, default 8: number of legal codes (1..NCODE); fixed at 8 in this release.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 code_valid  input  1  code is present this cycle.
REQ-006 code  input  4  select-decoder output code; legal values 1..8.
REQ-007 clr  input  1  single-cycle request to zero all counters.
REQ-008 rd_req  input  1  read request.
REQ-009 rd_idx  input  3  counter to read; index i maps to code i+1.
REQ-010 busy  output  1  high while a clear sweep is in progress.
REQ-011 rd_valid  output  1  rd_count is valid this cycle.
REQ-012 rd_count  output  CNT_W  counter value returned for the read.
REQ-013 last_code  output  4  most recent accepted legal code.
REQ-014 change  output  1  one-cycle pulse when an accepted legal code differs from last_code.
REQ-015 err_cnt  output  CNT_W  count of illegal codes (0, 9..15) seen with code_valid.
REQ-016 drop  output  1  sticky flag: a code arrived while busy.

Function
REQ-017 SHALL implement a state machine with states RUN and CLEAR.
REQ-018 In RUN, code_valid with a legal code SHALL increment counter[code-1] on the same edge.
REQ-019 In RUN, code_valid with an illegal code SHALL increment err_cnt and SHALL leave last_code, change and all hit counters unchanged.
REQ-020 All counters SHALL saturate at all-ones and never wrap.
REQ-021 For an accepted legal code, last_code SHALL update on the same edge; change SHALL be high for the following cycle only when the new code differs from the old last_code.
REQ-022 The first legal code after reset or after a clear SHALL pulse change, because last_code holds 0.
REQ-023 A read SHALL have 1-cycle latency: rd_req sampled at edge N gives rd_valid=1 and rd_count in the cycle after edge N.
REQ-024 A read and an increment of the same counter on the same edge SHALL return the pre-increment value.
REQ-025 rd_req while busy SHALL be ignored: no rd_valid is produced.
REQ-026 clr in RUN SHALL enter CLEAR on the next edge with busy=1.
REQ-027 CLEAR SHALL zero one hit counter per cycle, indices 0..7, then zero err_cnt and last_code on the eighth cycle, and return to RUN; busy SHALL be high for exactly 8 cycles.
REQ-028 clr while busy SHALL be ignored and SHALL NOT restart the sweep.
REQ-029 code_valid while busy SHALL be discarded and SHALL set drop; drop SHALL clear only on reset.
REQ-030 clr and code_valid on the same edge in RUN: the code SHALL be counted, and CLEAR SHALL be entered afterwards.

Reset
REQ-031 rst_n low SHALL immediately force RUN, all counters to 0, last_code=0, change=0, rd_valid=0, rd_count=0, busy=0 and drop=0.
REQ-032 Reset asserted during CLEAR SHALL abort the sweep; RUN SHALL resume on the first edge after release.

Structure
REQ-033 A shared package SHALL hold the state enum (RUN, CLEAR), the legal-code bounds CODE_MIN=1 and CODE_MAX=8, and the sweep length 8.
REQ-034 A single sub-module sat_counter (CNT_W wide, with inc and clr inputs) SHALL be instantiated 9 times: 8 hit counters plus err_cnt.

Verification
REQ-035 Reset, then codes 1,1,3: reading idx0 returns 2, idx2 returns 1, idx1 returns 0; change pulses twice.
REQ-036 Codes 0 and 12 with code_valid: err_cnt=2, last_code unchanged, no change pulse.
REQ-037 Drive code 5 for 300 cycles with CNT_W=8: reading idx4 returns 255.
REQ-038 clr, then code 2 on the next cycle: busy is high for 8 cycles, drop=1, all reads after the sweep return 0, and last_code=0.
REQ-039 rd_req idx3 on the same edge as code 4: rd_count shows the old value; a second read shows old+1.
REQ-040 rst_n low on the 4th CLEAR cycle: all outputs go to 0 at once; after release the block accepts code 7 and reading idx6 returns 1.

Source files
------------

// File: rtl/code_monitor_pkg.sv
// Shared types and constants for the code monitor: FSM states, legal code range, sweep length.
package code_monitor_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int CODE_W    = 4;
  localparam int IDX_W     = 3;
  localparam int CODE_MIN  = 1;
  localparam int CODE_MAX  = 8;
  localparam int SWEEP_LEN = 8;

  function automatic logic isLegal(input logic [CODE_W-1:0] c);
    return (c >= CODE_W'(CODE_MIN)) && (c <= CODE_W'(CODE_MAX));
  endfunction

endpackage

// File: rtl/code_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/code_monitor.sv
// Per-code hit counters for a select-decoder output, with error count, change pulse,
// one-cycle-latency readback and a multi-cycle clear sweep.
module code_monitor
  import code_monitor_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int NCODE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              busy,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CODE_W-1:0] last_code,
  output logic              change,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              drop
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sweep_q, sweep_d;
  logic [CODE_W-1:0]   last_code_q, last_code_d;
  logic                change_q, change_d;
  logic                rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic                drop_q, drop_d;

  logic [CNT_W-1:0]    hit_cnt [NCODE];
  logic [NCODE-1:0]    hit_inc, hit_clr;
  logic                err_inc, err_clr;

  for (genvar g = 0; g < NCODE; g++) begin : g_hit
    sat_counter #(.CNT_W(CNT_W)) u_hit (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (hit_inc[g]),
      .clr_i   (hit_clr[g]),
      .count_o (hit_cnt[g])
    );
  end

  sat_counter #(.CNT_W(CNT_W)) u_err (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (err_inc),
    .clr_i   (err_clr),
    .count_o (err_cnt)
  );

  // Reads sample the counter before this edge's increment, giving pre-increment values.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    last_code_d = last_code_q;
    change_d    = 1'b0;
    rd_valid_d  = 1'b0;
    rd_count_d  = rd_count_q;
    drop_d      = drop_q;
    hit_inc     = '0;
    hit_clr     = '0;
    err_inc     = 1'b0;
    err_clr     = 1'b0;

    case (state_q)
      RUN: begin
        if (code_valid) begin
          if (isLegal(code)) begin
            hit_inc[IDX_W'(code - 4'd1)] = 1'b1;
            last_code_d = code;
            change_d    = (code != last_code_q);
          end else begin
            err_inc = 1'b1;
          end
        end
        if (rd_req) begin
          rd_valid_d = 1'b1;
          rd_count_d = hit_cnt[rd_idx];
        end
        if (clr) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end

      CLEAR: begin
        hit_clr[sweep_q] = 1'b1;
        if (code_valid) begin
          drop_d = 1'b1;
        end
        if (sweep_q == IDX_W'(SWEEP_LEN - 1)) begin
          err_clr     = 1'b1;
          last_code_d = '0;
          state_d     = RUN;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      sweep_q     <= '0;
      last_code_q <= '0;
      change_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_count_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      last_code_q <= last_code_d;
      change_q    <= change_d;
      rd_valid_q  <= rd_valid_d;
      rd_count_q  <= rd_count_d;
      drop_q      <= drop_d;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign rd_valid  = rd_valid_q;
  assign rd_count  = rd_count_q;
  assign last_code = last_code_q;
  assign change    = change_q;
  assign drop      = drop_q;

endmodule
